// File: rtl/pio_pin_bank.sv
// GPIO pin bank for the PIO state machine: masked, rotated level/direction writes and a rotated,
// masked input view. Define PIO_PIN_INPUT_SYNC_EN to insert a SYNC_STAGES-deep input synchroniser.
module pio_pin_bank #(
  parameter int unsigned NUM_PINS    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned BW         = $clog2(NUM_PINS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BW-1:0]       cfg_inBase,
  input  logic [5:0]          cfg_inCount,
  input  logic [BW-1:0]       cfg_outBase,
  input  logic [5:0]          cfg_outCount,
  input  logic [BW-1:0]       cfg_sideBase,
  input  logic [2:0]          cfg_sideCount,
  input  logic                cfg_sidePindir,
  output logic [31:0]         read,
  input  logic [31:0]         out_data,
  input  logic                out_we,
  input  logic [31:0]         dir_data,
  input  logic                dir_we,
  input  logic [4:0]          side_data,
  input  logic                side_we,
  input  logic [NUM_PINS-1:0] pins_in,
  output logic [NUM_PINS-1:0] pins_out,
  output logic [NUM_PINS-1:0] pins_oe
);

  localparam int PinMask = int'(NUM_PINS) - 1;

  if (NUM_PINS < 2 || NUM_PINS > 32 || (NUM_PINS & (NUM_PINS - 1)) != 0) begin : g_bad_pins
    $error("NUM_PINS must be a power of two in 2..32");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be in 1..3");
  end

  function automatic int clamp_count(int count, int limit);
    int lim;
    lim = (limit < int'(NUM_PINS)) ? limit : int'(NUM_PINS);
    return (count > lim) ? lim : count;
  endfunction

  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] oe_q, oe_d;
  logic [NUM_PINS-1:0] sync_in;
  logic [31:0]         side_ext;
  logic [31:0]         read_d;
  int                  in_cnt, out_cnt, side_cnt;

  always_comb begin
    in_cnt   = clamp_count(int'(cfg_inCount), 32);
    out_cnt  = clamp_count(int'(cfg_outCount), 32);
    side_cnt = clamp_count(int'(cfg_sideCount), 5);
    side_ext = {27'b0, side_data};
  end

  // Walk pins rather than window bits so each pin sees at most one window index.
  always_comb begin
    int off;
    out_d = out_q;
    oe_d  = oe_q;
    off   = 0;
    for (int p = 0; p < int'(NUM_PINS); p++) begin
      off = (p - int'(cfg_outBase)) & PinMask;
      if (out_we && off < out_cnt) out_d[p] = out_data[off];
      if (dir_we && off < out_cnt) oe_d[p] = dir_data[off];
      // Side-set is applied last so it wins on overlapping pins.
      off = (p - int'(cfg_sideBase)) & PinMask;
      if (side_we && off < side_cnt) begin
        if (cfg_sidePindir) oe_d[p] = side_ext[off];
        else                out_d[p] = side_ext[off];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

`ifdef PIO_PIN_INPUT_SYNC_EN
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pins_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
`else
  assign sync_in = pins_in;
`endif

  always_comb begin
    read_d = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < in_cnt) read_d[i] = sync_in[(int'(cfg_inBase) + i) & PinMask];
    end
  end

  // Forced low during reset so the unsynchronised build also reads zero.
  assign read     = reset ? '0 : read_d;
  assign pins_out = out_q;
  assign pins_oe  = oe_q;

endmodule

// File: tb/tb_pio_pin_bank.sv
// Scoreboard bench for pio_pin_bank: directed cases then random traffic checked against a
// window-level reference model.
module tb_pio_pin_bank;

  localparam int N    = 32;
  localparam int SYNC = 2;
`ifdef PIO_PIN_INPUT_SYNC_EN
  localparam int LAT = SYNC - 1;
`else
  localparam int LAT = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  cfg_inBase, cfg_outBase, cfg_sideBase;
  logic [5:0]  cfg_inCount, cfg_outCount;
  logic [2:0]  cfg_sideCount;
  logic        cfg_sidePindir;
  logic [31:0] read;
  logic [31:0] out_data, dir_data;
  logic        out_we, dir_we, side_we;
  logic [4:0]  side_data;
  logic [31:0] pins_in, pins_out, pins_oe;

  pio_pin_bank #(.NUM_PINS(N), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset),
    .cfg_inBase(cfg_inBase), .cfg_inCount(cfg_inCount),
    .cfg_outBase(cfg_outBase), .cfg_outCount(cfg_outCount),
    .cfg_sideBase(cfg_sideBase), .cfg_sideCount(cfg_sideCount),
    .cfg_sidePindir(cfg_sidePindir), .read(read),
    .out_data(out_data), .out_we(out_we), .dir_data(dir_data), .dir_we(dir_we),
    .side_data(side_data), .side_we(side_we),
    .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] oe;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  bit   [31:0] hist[$];
  bit   [31:0] m_out, m_oe;
  int          errors = 0;
  int          checks = 0;

  function automatic int clampc(int c, int lim);
    int r;
    r = (c > lim) ? lim : c;
    return (r > N) ? N : r;
  endfunction

  // Bit i of data lands on pin (base+i) mod N for i < cnt.
  function automatic bit [31:0] win_write(bit [31:0] v, int base, int cnt, bit [31:0] data);
    for (int i = 0; i < cnt; i++) v[(base + i) % N] = data[i];
    return v;
  endfunction

  function automatic bit [31:0] win_read(bit [31:0] src, int base, int cnt);
    bit [31:0] r;
    r = '0;
    for (int i = 0; i < cnt; i++) r[i] = src[(base + i) % N];
    return r;
  endfunction

  // Predict the state visible after the coming edge, queue it, then move to the next negedge.
  task automatic step();
    exp_t      e;
    bit [31:0] sv;
    if (reset) begin
      m_out = '0;
      m_oe  = '0;
      hist.push_back('0);
    end else begin
      if (out_we) m_out = win_write(m_out, cfg_outBase, clampc(cfg_outCount, 32), out_data);
      if (dir_we) m_oe = win_write(m_oe, cfg_outBase, clampc(cfg_outCount, 32), dir_data);
      if (side_we) begin
        if (cfg_sidePindir)
          m_oe = win_write(m_oe, cfg_sideBase, clampc(cfg_sideCount, 5), {27'b0, side_data});
        else
          m_out = win_write(m_out, cfg_sideBase, clampc(cfg_sideCount, 5), {27'b0, side_data});
      end
      hist.push_back(pins_in);
    end
    sv = (hist.size() > LAT) ? hist[hist.size() - 1 - LAT] : '0;
    e.out = m_out;
    e.oe  = m_oe;
    e.rd  = reset ? '0 : win_read(sv, cfg_inBase, clampc(cfg_inCount, 32));
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle();
    reset = 1'b0; out_we = 1'b0; dir_we = 1'b0; side_we = 1'b0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every edge with a pending prediction is compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pins_out", pins_out, e.out);
        check("pins_oe", pins_oe, e.oe);
        check("read", read, e.rd);
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_inBase = '0; cfg_inCount = '0; cfg_outBase = '0; cfg_outCount = '0;
    cfg_sideBase = '0; cfg_sideCount = '0; cfg_sidePindir = 1'b0;
    out_data = '0; dir_data = '0; side_data = '0; pins_in = '0;
    out_we = 1'b0; dir_we = 1'b0; side_we = 1'b0;
    @(negedge clock);

    // Reset dominates strobes, including a live input window.
    reset = 1'b1; out_we = 1'b1; dir_we = 1'b1; side_we = 1'b1;
    out_data = '1; dir_data = '1; side_data = '1; cfg_outCount = 6'd32; cfg_sideCount = 3'd5;
    cfg_inCount = 6'd32; pins_in = 32'hDEAD_BEEF;
    repeat (3) begin
      step();
      check("read_in_reset", read, 32'h0);
    end

    // First cycle after release honours a level write.
    idle(); out_we = 1'b1; cfg_outBase = 5'd0; cfg_outCount = 6'd8; out_data = 32'h5A;
    cfg_inCount = 6'd0; step();

    // Wrapping OUT window.
    idle(); out_we = 1'b1; cfg_outBase = 5'd30; cfg_outCount = 6'd4; out_data = 32'hF; step();

    // Side-set beats OUT on overlapping pins.
    idle(); out_we = 1'b1; cfg_outBase = 5'd0; cfg_outCount = 6'd8; out_data = 32'h0;
    side_we = 1'b1; cfg_sideBase = 5'd4; cfg_sideCount = 3'd2; side_data = 5'b00011;
    cfg_sidePindir = 1'b0; step();

    // Zero-count direction write is a no-op, then count 8.
    idle(); dir_we = 1'b1; cfg_outBase = 5'd8; cfg_outCount = 6'd0; dir_data = '1; step();
    idle(); dir_we = 1'b1; cfg_outCount = 6'd8; step();

    // Input window at the top of the bank, then count zero.
    idle(); pins_in = 32'hA500_0000; cfg_inBase = 5'd24; cfg_inCount = 6'd8;
    repeat (SYNC + 1) step();
    cfg_inCount = 6'd0; step();

    // Side-set to directions, wrapping from pin 31.
    idle(); side_we = 1'b1; cfg_sidePindir = 1'b1; cfg_sideBase = 5'd31; cfg_sideCount = 3'd2;
    side_data = 5'b00001; step();

    // Over-range counts clamp to the window maximum.
    idle(); out_we = 1'b1; side_we = 1'b1; cfg_outBase = 5'd3; cfg_outCount = 6'd63;
    out_data = 32'h1234_5678; cfg_sideBase = 5'd29; cfg_sideCount = 3'd7; side_data = 5'b10110;
    cfg_sidePindir = 1'b0; cfg_inBase = 5'd7; cfg_inCount = 6'd50; step();

    for (int k = 0; k < 250; k++) begin
      reset          = ($urandom_range(0, 39) == 0);
      cfg_inBase     = 5'($urandom);
      cfg_outBase    = 5'($urandom);
      cfg_sideBase   = 5'($urandom);
      cfg_inCount    = 6'($urandom_range(0, 63));
      cfg_outCount   = 6'($urandom_range(0, 63));
      cfg_sideCount  = 3'($urandom_range(0, 7));
      cfg_sidePindir = 1'($urandom);
      out_data       = $urandom;
      dir_data       = $urandom;
      side_data      = 5'($urandom);
      out_we         = 1'($urandom);
      dir_we         = 1'($urandom);
      side_we        = 1'($urandom);
      if ($urandom_range(0, 2) == 0) pins_in = $urandom;
      step();
    end
    idle();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clock);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
